// File: rtl/input_route_unit.sv
// ---------------------------------------------------------------------------
// input_route_unit
//
// Route-computation stage for one router input port (wormhole switching).
// The destination carried by each HEAD flit is decoded with XY or YX
// dimension-order routing. The resulting direction is latched for the whole
// packet, and every flit of the packet is forwarded through a one-deep
// valid/ready output register tagged with that direction. Packets that
// cannot be routed are consumed and counted, as are orphan flits.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_data     incoming flit (DSIZE bits)
//   in_valid    in_data is valid
//   in_ready    flit is accepted this cycle (in_valid && in_ready)
//   out_data    registered flit
//   out_vc      direction of out_data: N=000 S=001 E=010 W=011 L=100 INV=111
//   out_valid   out_data / out_vc are valid
//   out_ready   downstream accepts the output
//   drop_count  saturating count of discarded packets and orphan flits
//   busy        a packet is in progress (state is not IDLE)
// ---------------------------------------------------------------------------
module input_route_unit #(
    parameter int         MSB_SLOT  = 5,
    parameter int         DSIZE     = 1 << MSB_SLOT,
    parameter int         RRSIZE    = 1 << (MSB_SLOT - 2),
    parameter logic       ALGORITHM = 1'b0,
    parameter logic [2:0] PORT      = 3'd0,
    parameter int         ROUTER_X  = 0,
    parameter int         ROUTER_Y  = 0,
    parameter int         MESH_X    = 4,
    parameter int         MESH_Y    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [2:0]       out_vc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       drop_count,
    output logic             busy
);

    localparam logic [2:0] DIR_N   = 3'b000;
    localparam logic [2:0] DIR_S   = 3'b001;
    localparam logic [2:0] DIR_E   = 3'b010;
    localparam logic [2:0] DIR_W   = 3'b011;
    localparam logic [2:0] DIR_L   = 3'b100;
    localparam logic [2:0] DIR_INV = 3'b111;

    localparam logic [RRSIZE-1:0] RX = RRSIZE'(ROUTER_X);
    localparam logic [RRSIZE-1:0] RY = RRSIZE'(ROUTER_Y);
    // One extra bit so that a mesh dimension of exactly 2**RRSIZE is representable.
    localparam logic [RRSIZE:0]   MX = (RRSIZE + 1)'(MESH_X);
    localparam logic [RRSIZE:0]   MY = (RRSIZE + 1)'(MESH_Y);

    typedef enum logic [1:0] {
        FT_VOID = 2'b00,
        FT_BODY = 2'b01,
        FT_TAIL = 2'b10,
        FT_HEAD = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PKT  = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    // Dimension-order route for a destination; INVALID for U-turns and
    // destinations outside the mesh.
    function automatic logic [2:0] route_calc(input logic [RRSIZE-1:0] dx,
                                              input logic [RRSIZE-1:0] dy);
        logic [2:0] r;
        if (dx == RX && dy == RY) begin
            r = DIR_L;
        end else if (ALGORITHM == 1'b0) begin
            if (dx != RX) r = (dx > RX) ? DIR_E : DIR_W;
            else          r = (dy < RY) ? DIR_N : DIR_S;
        end else begin
            if (dy != RY) r = (dy > RY) ? DIR_S : DIR_N;
            else          r = (dx < RX) ? DIR_W : DIR_E;
        end
        if (r == PORT || {1'b0, dx} >= MX || {1'b0, dy} >= MY) r = DIR_INV;
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state, state_nxt;
    logic [2:0]       route_reg, route_nxt;
    logic [DSIZE-1:0] data_nxt;
    logic [2:0]       vc_nxt;
    logic             valid_nxt;
    logic [7:0]       drop_nxt;

    flit_type_t       ftype;
    logic [2:0]       head_route;
    logic             accept;
    logic             fwd;
    logic [2:0]       fwd_vc;
    logic             count_drop;

    assign ftype      = flit_type_t'(in_data[1:0]);
    assign head_route = route_calc(in_data[DSIZE-1 -: RRSIZE],
                                   in_data[DSIZE-1-RRSIZE -: RRSIZE]);
    // DROP consumes unconditionally; elsewhere even discarded flits wait for
    // output space so that accept order matches output order.
    assign in_ready   = (state == ST_DROP) || !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        route_nxt  = route_reg;
        fwd        = 1'b0;
        fwd_vc     = route_reg;
        count_drop = 1'b0;

        if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    unique case (ftype)
                        FT_HEAD: begin
                            if (head_route != DIR_INV) begin
                                fwd       = 1'b1;
                                fwd_vc    = head_route;
                                route_nxt = head_route;
                                state_nxt = ST_PKT;
                            end else begin
                                count_drop = 1'b1;
                                state_nxt  = ST_DROP;
                            end
                        end
                        FT_BODY, FT_TAIL: count_drop = 1'b1;
                        default: ;
                    endcase
                end
                ST_PKT: begin
                    unique case (ftype)
                        FT_BODY: fwd = 1'b1;
                        FT_TAIL: begin
                            fwd       = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                        FT_HEAD: count_drop = 1'b1;
                        default: ;
                    endcase
                end
                ST_DROP: begin
                    if (ftype == FT_TAIL) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // A load in the same cycle as a drain keeps out_valid high (no bubble).
        data_nxt  = out_data;
        vc_nxt    = out_vc;
        valid_nxt = out_valid;
        if (fwd) begin
            data_nxt  = in_data;
            vc_nxt    = fwd_vc;
            valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end

        drop_nxt = count_drop ? sat_inc(drop_count) : drop_count;
    end

    // ---- output register stage ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            route_reg  <= DIR_INV;
            out_data   <= '0;
            out_vc     <= DIR_INV;
            out_valid  <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            route_reg  <= route_nxt;
            out_data   <= data_nxt;
            out_vc     <= vc_nxt;
            out_valid  <= valid_nxt;
            drop_count <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_input_route_unit.sv
// ---------------------------------------------------------------------------
// tb_input_route_unit
//
// Directed bench for input_route_unit. Two instances share clock, reset and
// stimulus: one configured for XY routing, one for YX. Router at (1,1),
// PORT = N (0), 4x4 mesh, 32-bit flits with 8-bit coordinates.
// ---------------------------------------------------------------------------
module tb_input_route_unit;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        xy_in_ready, yx_in_ready;
    logic [31:0] xy_out_data, yx_out_data;
    logic [2:0]  xy_out_vc,   yx_out_vc;
    logic        xy_out_valid, yx_out_valid;
    logic [7:0]  xy_drop,     yx_drop;
    logic        xy_busy,     yx_busy;

    int n_cmp;
    int n_bad;

    input_route_unit #(
        .MSB_SLOT(5), .ALGORITHM(1'b0), .PORT(3'd0),
        .ROUTER_X(1), .ROUTER_Y(1), .MESH_X(4), .MESH_Y(4)
    ) dut_xy (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(xy_in_ready),
        .out_data(xy_out_data), .out_vc(xy_out_vc), .out_valid(xy_out_valid),
        .out_ready(out_ready), .drop_count(xy_drop), .busy(xy_busy)
    );

    input_route_unit #(
        .MSB_SLOT(5), .ALGORITHM(1'b1), .PORT(3'd0),
        .ROUTER_X(1), .ROUTER_Y(1), .MESH_X(4), .MESH_Y(4)
    ) dut_yx (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(yx_in_ready),
        .out_data(yx_out_data), .out_vc(yx_out_vc), .out_valid(yx_out_valid),
        .out_ready(out_ready), .drop_count(yx_drop), .busy(yx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (xy_out_valid !== 1'b0 || xy_out_data !== 32'h0 || xy_out_vc !== 3'b111 ||
            xy_drop !== 8'h00 || xy_busy !== 1'b0 || xy_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b data=%h vc=%b drop=%h busy=%b rdy=%b, want 0 0 111 00 0 1",
                     xy_out_valid, xy_out_data, xy_out_vc, xy_drop, xy_busy, xy_in_ready);
        end
    endtask

    task automatic test_xy_packet();
        apply_reset();
        in_valid = 1'b1;
        in_data  = 32'h0300_0003;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b1 || xy_out_vc !== 3'b010 || xy_out_data !== 32'h0300_0003 || xy_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL xy_head: got valid=%b vc=%b data=%h busy=%b, want 1 010 03000003 1",
                     xy_out_valid, xy_out_vc, xy_out_data, xy_busy);
        end
        in_data = 32'h0300_0001;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b1 || xy_out_vc !== 3'b010 || xy_out_data !== 32'h0300_0001) begin
            n_bad++;
            $display("FAIL xy_body: got valid=%b vc=%b data=%h, want 1 010 03000001",
                     xy_out_valid, xy_out_vc, xy_out_data);
        end
        in_data = 32'h0300_0002;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b1 || xy_out_vc !== 3'b010 || xy_out_data !== 32'h0300_0002 || xy_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL xy_tail: got valid=%b vc=%b data=%h busy=%b, want 1 010 03000002 0",
                     xy_out_valid, xy_out_vc, xy_out_data, xy_busy);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b0 || xy_drop !== 8'h00) begin
            n_bad++;
            $display("FAIL xy_drain: got valid=%b drop=%h, want 0 00", xy_out_valid, xy_drop);
        end
    endtask

    task automatic test_yx_uturn();
        logic [31:0] flits [3];
        logic [2:0]  want_busy [3];
        flits     = '{32'h0300_0003, 32'h0300_0001, 32'h0300_0002};
        want_busy = '{3'd1, 3'd1, 3'd0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = flits[i];
            #1;
            n_cmp++;
            if (yx_in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL yx_uturn_ready[%0d]: got %b, want 1", i, yx_in_ready);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (yx_out_valid !== 1'b0 || yx_busy !== want_busy[i][0]) begin
                n_bad++;
                $display("FAIL yx_uturn_flit[%0d]: got valid=%b busy=%b, want 0 %b",
                         i, yx_out_valid, yx_busy, want_busy[i][0]);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (yx_drop !== 8'h01) begin
            n_bad++;
            $display("FAIL yx_uturn_count: got %h, want 01", yx_drop);
        end
    endtask

    task automatic test_routes();
        apply_reset();
        // dest (3,3): XY -> E, YX -> S
        in_valid = 1'b1;
        in_data  = 32'h0303_0003;
        tick();
        n_cmp++;
        if (xy_out_vc !== 3'b010 || yx_out_vc !== 3'b001 || !xy_out_valid || !yx_out_valid) begin
            n_bad++;
            $display("FAIL route_33: got xy=%b yx=%b, want 010 001", xy_out_vc, yx_out_vc);
        end
        in_data = 32'h0303_0002;
        tick();
        // dest (0,2): XY -> W, YX -> S
        in_data = 32'h0002_0003;
        tick();
        n_cmp++;
        if (xy_out_vc !== 3'b011 || yx_out_vc !== 3'b001 || !xy_out_valid || !yx_out_valid) begin
            n_bad++;
            $display("FAIL route_02: got xy=%b yx=%b, want 011 001", xy_out_vc, yx_out_vc);
        end
        in_data = 32'h0002_0002;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bounds_local();
        apply_reset();
        in_valid = 1'b1;
        in_data  = 32'h0105_0003;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b0 || xy_drop !== 8'h01 || xy_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bounds_drop: got valid=%b drop=%h busy=%b, want 0 01 1",
                     xy_out_valid, xy_drop, xy_busy);
        end
        in_data = 32'h0105_0002;
        tick();
        in_data = 32'h0101_0003;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b1 || xy_out_vc !== 3'b100 || xy_out_data !== 32'h0101_0003 || xy_drop !== 8'h01) begin
            n_bad++;
            $display("FAIL local_route: got valid=%b vc=%b data=%h drop=%h, want 1 100 01010003 01",
                     xy_out_valid, xy_out_vc, xy_out_data, xy_drop);
        end
        in_data = 32'h0101_0002;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] rest [3];
        rest = '{32'h0300_0011, 32'h0300_0021, 32'h0300_0032};
        apply_reset();
        in_valid = 1'b1;
        in_data  = 32'h0300_0003;
        tick();
        out_ready = 1'b0;
        in_data   = rest[0];
        #1;
        n_cmp++;
        if (xy_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_ready: got %b, want 0", xy_in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (xy_out_valid !== 1'b1 || xy_out_data !== 32'h0300_0003 || xy_out_vc !== 3'b010 || xy_in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h vc=%b rdy=%b, want 1 03000003 010 0",
                         i, xy_out_valid, xy_out_data, xy_out_vc, xy_in_ready);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rest[i];
            tick();
            n_cmp++;
            if (xy_out_valid !== 1'b1 || xy_out_data !== rest[i] || xy_out_vc !== 3'b010) begin
                n_bad++;
                $display("FAIL release_order[%0d]: got valid=%b data=%h vc=%b, want 1 %h 010",
                         i, xy_out_valid, xy_out_data, xy_out_vc, rest[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (xy_out_valid !== 1'b0 || xy_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL release_end: got valid=%b busy=%b, want 0 0", xy_out_valid, xy_busy);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (xy_drop !== 8'h0A) begin
            n_bad++;
            $display("FAIL orphan_count10: got %h, want 0a", xy_drop);
        end
        for (int i = 10; i < 255; i++) tick();
        n_cmp++;
        if (xy_drop !== 8'hFF) begin
            n_bad++;
            $display("FAIL orphan_count255: got %h, want ff", xy_drop);
        end
        tick();
        n_cmp++;
        if (xy_drop !== 8'hFF || xy_out_valid !== 1'b0 || xy_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL orphan_saturate: got drop=%h valid=%b busy=%b, want ff 0 0",
                     xy_drop, xy_out_valid, xy_busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        in_valid = 1'b1;
        in_data  = 32'h0300_0003;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (xy_out_valid !== 1'b0 || xy_out_data !== 32'h0 || xy_out_vc !== 3'b111 ||
            xy_busy !== 1'b0 || xy_drop !== 8'h00 || xy_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b data=%h vc=%b busy=%b drop=%h rdy=%b, want 0 0 111 0 00 1",
                     xy_out_valid, xy_out_data, xy_out_vc, xy_busy, xy_drop, xy_in_ready);
        end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0300_0001;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (xy_drop !== 8'h01 || xy_out_valid !== 1'b0 || xy_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_orphan: got drop=%h valid=%b busy=%b, want 01 0 0",
                     xy_drop, xy_out_valid, xy_busy);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_xy_packet();
        test_yx_uturn();
        test_routes();
        test_bounds_local();
        test_backpressure();
        test_saturation();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_route_unit.md
# input_route_unit

Parametrised, registered route-computation stage for one router input port, for wormhole switching. It decodes the destination on each head flit using XY or YX dimension-order routing and latches the resulting output direction for the whole packet. It forwards head, body and tail flits through a one-deep valid/ready output register, each tagged with the latched direction. Packets it cannot route are consumed and counted. It sits between the input buffer of a port and the crossbar/VC allocator.

## Interface
- MSB_SLOT, 5, log2 of flit width
- DSIZE, 1<<MSB_SLOT, flit width in bits
- RRSIZE, 1<<(MSB_SLOT-2), width of each destination coordinate
- ALGORITHM, 1'b0, routing mode: 0 = XY, 1 = YX
- PORT, 3'd0, direction code of this input port; a route equal to PORT is a U-turn and is invalid
- ROUTER_X, 0, X coordinate of this router
- ROUTER_Y, 0, Y coordinate of this router
- MESH_X, 4, mesh columns; a destination X ≥ MESH_X is invalid
- MESH_Y, 4, mesh rows; a destination Y ≥ MESH_Y is invalid
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  DSIZE  incoming flit
- in_valid  input  1  in_data is valid
- in_ready  output  1  this block accepts in_data on this cycle
- out_data  output  DSIZE  registered flit
- out_vc  output  3  direction for out_data: N=000, S=001, E=010, W=011, L=100, INVALID=111
- out_valid  output  1  out_data and out_vc are valid
- out_ready  input  1  downstream accepts the output
- drop_count  output  8  saturating count of discarded packets and orphan flits
- busy  output  1  a packet is in progress (state is not IDLE)

## Operation
- Flit fields: dest_x = in_data[DSIZE-1 -: RRSIZE]; dest_y = the next RRSIZE bits below it; type = in_data[1:0], where 11 = HEAD, 01 = BODY, 10 = TAIL, 00 = idle/void.
- A flit is accepted when in_valid && in_ready.
- Route function (HEAD only): if dest equals (ROUTER_X, ROUTER_Y), the route is L.
  - XY mode: if dest_x ≠ ROUTER_X, the route is E when dest_x > ROUTER_X, otherwise W. If dest_x = ROUTER_X, the route is N when dest_y < ROUTER_Y, otherwise S.
  - YX mode: if dest_y ≠ ROUTER_Y, the route is S when dest_y > ROUTER_Y, otherwise N. If dest_y = ROUTER_Y, the route is W when dest_x < ROUTER_X, otherwise E.
  - The route is INVALID if it equals PORT or the destination is outside the mesh bounds.
  - All comparisons are unsigned, RRSIZE wide.
- FSM states: IDLE, PKT, DROP.
  - IDLE:
    - Valid HEAD: load the output register, latch the route into route_reg, go to PKT.
    - Invalid HEAD: discard the flit, increment drop_count, go to DROP.
    - BODY or TAIL (orphan): discard, increment drop_count, stay in IDLE.
    - Type 00: discard silently.
  - PKT:
    - BODY: forward with out_vc = route_reg.
    - TAIL: forward with out_vc = route_reg, go to IDLE.
    - HEAD: protocol error; discard, increment drop_count, stay in PKT.
    - Type 00: discard silently.
  - DROP: every flit is discarded with no further counting; TAIL goes to IDLE.
- in_ready:
  - In DROP: 1.
  - Otherwise: !out_valid || out_ready.
  - Discarded flits in IDLE/PKT also need this condition to be accepted, which preserves ordering.
- Output register:
  - Loads on a forwarded accept.
  - out_valid clears on out_valid && out_ready when no new forward happens in the same cycle.
  - out_data and out_vc are held stable while out_valid && !out_ready.
- drop_count saturates at 8'hFF.
- busy = (state ≠ IDLE).

## Timing
- Reset values: out_valid = 0, out_data = 0, out_vc = 3'b111, drop_count = 0, state = IDLE, busy = 0, route_reg = 3'b111, in_ready = 1.
- Reset takes effect immediately and asynchronously. Reset in the middle of a packet abandons it; the next flit is interpreted from IDLE.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 flit per cycle while out_ready is held at 1.
- Simultaneous drain and load: out_valid stays 1 and the new flit replaces the old one, with no bubble.
- The state transition on TAIL happens in the accept cycle. A HEAD on the following cycle is routed fresh.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_data to any output.

## Test plan
Test configuration: DSIZE = 32, RRSIZE = 8, ROUTER = (1,1), PORT = 0, mesh 4x4.
1. XY mode, HEAD 32'h0300_0003, BODY 32'h0300_0001, TAIL 32'h0300_0002, out_ready = 1 -> three consecutive out_valid cycles, each with out_vc = 010 (E); busy drops after the tail; drop_count = 0.
2. YX mode, HEAD 32'h0300_0003 (route N equals PORT) followed by BODY and TAIL -> no out_valid; in_ready stays 1; drop_count = 1; state returns to IDLE after the tail.
3. XY mode, HEAD 32'h0105_0003 (dest_y = 5 ≥ MESH_Y) -> dropped; drop_count = 1. HEAD 32'h0101_0003 -> out_vc = 100 (L).
4. out_ready held at 0 for 3 cycles during a packet -> in_ready = 0; out_data and out_vc stay stable; on release, flits arrive in order with none lost.
5. Orphan BODY in IDLE 256 times -> drop_count saturates at 8'hFF with no wrap.
6. Assert reset while in PKT with out_valid = 1 -> outputs go immediately to their reset values. A BODY flit after reset is counted as an orphan.
